// File: rtl/fb_read_arbiter.sv
// Display/secondary read arbiter for dmem port 1; display has fixed priority.
// Optional starvation guard enabled by defining FB_ARB_STARVE_GUARD_EN.
module fb_read_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          s_req,
    input  logic [AW-1:0] s_addr,
    output logic          s_ack,
    output logic          s_rvalid,
    output logic [DW-1:0] s_rdata,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          misalign
);

    logic          grant_d;
    logic          grant_s;
    logic          force_s;
    logic          d_rvalid_q, d_rvalid_d;
    logic          s_rvalid_q, s_rvalid_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] s_rdata_q, s_rdata_d;
    logic          misalign_q, misalign_d;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          force_s_q, force_s_d;

    assign force_s = force_s_q;

    // force_s is raised on the same edge the count reaches the limit,
    // so the forced grant lands in cycle STARVE_LIMIT+1.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        force_s_d    = force_s_q;
        if (grant_s) begin
            starve_cnt_d = '0;
            force_s_d    = 1'b0;
        end else if (s_req) begin
            if (starve_cnt_q < CW'(STARVE_LIMIT))
                starve_cnt_d = starve_cnt_q + 1'b1;
            if (starve_cnt_q >= CW'(STARVE_LIMIT - 1))
                force_s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            force_s_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            force_s_q    <= force_s_d;
        end
    end
`else
    assign force_s = 1'b0;
`endif

    // Grants are masked while reset is held so all outputs read zero.
    always_comb begin
        grant_d = reset & d_req & ~(force_s & s_req);
        grant_s = reset & s_req & ~grant_d;
    end

    always_comb begin
        mem_addr = '0;
        if (grant_d)
            mem_addr = {d_addr[AW-1:2], 2'b00};
        else if (grant_s)
            mem_addr = {s_addr[AW-1:2], 2'b00};
    end

    always_comb begin
        d_rvalid_d = grant_d;
        s_rvalid_d = grant_s;
        d_rdata_d  = grant_d ? mem_rdata : d_rdata_q;
        s_rdata_d  = grant_s ? mem_rdata : s_rdata_q;
        misalign_d = misalign_q
                   | (grant_d & (|d_addr[1:0]))
                   | (grant_s & (|s_addr[1:0]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_rvalid_q <= 1'b0;
            s_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            s_rdata_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            d_rvalid_q <= d_rvalid_d;
            s_rvalid_q <= s_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            s_rdata_q  <= s_rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign d_ack    = grant_d;
    assign s_ack    = grant_s;
    assign d_rvalid = d_rvalid_q;
    assign s_rvalid = s_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign s_rdata  = s_rdata_q;
    assign misalign = misalign_q;

endmodule
